gam_param_writer: RTL and testbench
===================================

Name: gam_param_writer

Overview:
- Producer side of the Gamma parameter memory: accepts a stream of 32-bit parameter words and writes them into the parameter BRAM in the fixed layout the gamma interface reads from.
- Layout: a 5-word global header (slot 0), then 5 words per subset. Subset s, field k (0..4) sits at byte address ((s+1)*5+k)*4. Field 3 is cx, field 4 is cy.
- Asserts parameters_done only after the last word has been committed to memory.
- Sits between the host/DMA parameter stream and the BRAM write port. The gamma interface uses the read port.

Parameters:
- MAX_SUBSETS, 14, largest accepted num_of_subsets; matches the 448-bit per-subset register capacity downstream.
- WORDS_PER_SUBSET, 5, words per subset record; also the header size.
- ADDR_W, 32, width of param_addr (byte address).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load using num_of_subsets sampled in the same cycle.
- num_of_subsets  in  32  subset count for this load.
- s_valid  in  1  input word valid.
- s_data  in  32  input parameter word.
- s_ready  out  1  writer can accept s_data this cycle.
- param_ea  out  1  BRAM port enable.
- param_wea  out  4  BRAM byte write enables.
- param_addr  out  ADDR_W  BRAM byte address.
- param_din  out  32  BRAM write data.
- parameters_done  out  1  level; memory image complete.
- busy  out  1  high in CHECK/WRITE/FLUSH.
- load_error  out  1  level; last start had an illegal subset count.
- words_written  out  32  count of words committed in the current load.

Behaviour:
- Reset values: s_ready=0, param_ea=0, param_wea=0, param_addr=0, param_din=0, parameters_done=0, busy=0, load_error=0, words_written=0, state=IDLE.
- Reset mid-load:
  - abandons the load next edge; no further writes.
  - already-written BRAM contents are not cleared.
- States and transitions:
  - IDLE: wait for start. On start, latch n=num_of_subsets, clear parameters_done, load_error and words_written, then go to CHECK.
  - CHECK (1 cycle):
    - if n==0 or n>MAX_SUBSETS: set load_error=1, go to ERROR.
    - else: total=(n+1)*WORDS_PER_SUBSET (at most 75, computed in 32 bits), word index w=0, go to WRITE.
  - WRITE:
    - s_ready=1.
    - A word is accepted when s_valid&&s_ready.
    - On accept: next cycle drives param_ea=1, param_wea=4'hF, param_addr=w*4, param_din=s_data; w increments.
    - On a cycle with no accept: next cycle param_ea=0, param_wea=0. param_addr and param_din hold their values.
    - When the accepted word has w==total-1: s_ready drops the following cycle and the state goes to FLUSH.
  - FLUSH (1 cycle): the final write is on the port this cycle. Next cycle: param_ea=0, parameters_done=1, go to DONE.
  - DONE: parameters_done held high. On start: behave as in IDLE (done drops the next cycle).
  - ERROR: load_error held high, no BRAM activity. On start: behave as in IDLE.
- words_written increments in the same cycle each write is driven onto the port.
- Write latency: 1 cycle from accept to the BRAM port.
- parameters_done rises exactly 1 cycle after the last write cycle, so the reader never sees done with stale memory.
- Throughput: one word per cycle; back-to-back s_valid is fully supported; gaps in s_valid are allowed.
- start while busy is ignored and does not re-latch n.
- start and reset in the same cycle: reset wins.
- s_valid outside WRITE is ignored (s_ready=0); no words are dropped silently while ready.
- param_wea is always either 0 or 4'hF; no partial-word writes.

Decomposition:
- Shared package gam_pkg:
  - WORDS_PER_SUBSET, MAX_SUBSETS, field offsets (CX_OFS=3, CY_OFS=4).
  - state encoding constants.
  - function param_byte_addr(subset, field) = ((subset+1)*5+field)*4, shared with the gamma interface.
- One natural sub-module: gam_param_addr_gen, holding the word counter, the total compare and the byte-address output. The FSM stays in the top.

Test Plan:
- n=1, 10 consecutive words 0xA0..0xA9 → writes at addrs 0,4,...,36 with matching data; cx(subset0)=0xA8 at addr 32, cy=0xA9 at addr 36; parameters_done rises 2 cycles after the last accept; words_written=10.
- n=14, 75 words with s_valid toggled every other cycle → 75 writes, no duplicates or gaps, last addr 296; done asserted; s_ready=0 thereafter.
- n=0, then n=15 → load_error=1 within 2 cycles of start; zero cycles with param_ea=1; parameters_done=0.
- n=3, reset pulsed after 7 accepted words → param_ea=0 from the next cycle on, all outputs at reset values; a new start with n=2 completes 15 words cleanly.
- start pulsed again mid-load (n=2, second start carries n=5) → ignored; load completes 15 words.
- From DONE, start with n=1 → parameters_done drops the next cycle, reloads 10 words, then reasserts.

Source files
------------

// File: rtl/gam_pkg.sv
// rtl/gam_pkg.sv - shared Gamma parameter-memory layout constants and state encoding
package gam_pkg;

  localparam int unsigned WORDS_PER_SUBSET = 5;
  localparam int unsigned MAX_SUBSETS      = 14;
  localparam int unsigned CX_OFS           = 3;
  localparam int unsigned CY_OFS           = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } gam_state_t;

  // Slot 0 is the global header, so subset s lives one record further on.
  function automatic logic [31:0] param_byte_addr(input logic [31:0] subset,
                                                  input logic [31:0] field);
    return ((subset + 32'd1) * 32'(WORDS_PER_SUBSET) + field) * 32'd4;
  endfunction

endpackage

// File: rtl/gam_param_addr_gen.sv
// rtl/gam_param_addr_gen.sv - word counter, end-of-load compare and BRAM byte address
module gam_param_addr_gen #(
  parameter int ADDR_W           = 32,
  parameter int WORDS_PER_SUBSET = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic [31:0]       num_subsets,
  input  logic              advance,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [31:0] word_idx;
  logic [31:0] total;

  always_ff @(posedge clock) begin
    if (reset) begin
      word_idx <= '0;
      total    <= '0;
      addr     <= '0;
    end else if (init) begin
      word_idx <= '0;
      total    <= (num_subsets + 32'd1) * 32'(WORDS_PER_SUBSET);
    end else if (advance) begin
      // Address is registered alongside the data so both reach the port together.
      addr     <= ADDR_W'({word_idx[29:0], 2'b00});
      word_idx <= word_idx + 32'd1;
    end
  end

  assign last = (word_idx == total - 32'd1);

endmodule

// File: rtl/gam_param_writer.sv
// rtl/gam_param_writer.sv - streams parameter words into the Gamma parameter BRAM layout
module gam_param_writer #(
  parameter int MAX_SUBSETS      = gam_pkg::MAX_SUBSETS,
  parameter int WORDS_PER_SUBSET = gam_pkg::WORDS_PER_SUBSET,
  parameter int ADDR_W           = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       num_of_subsets,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              param_ea,
  output logic [3:0]        param_wea,
  output logic [ADDR_W-1:0] param_addr,
  output logic [31:0]       param_din,
  output logic              parameters_done,
  output logic              busy,
  output logic              load_error,
  output logic [31:0]       words_written
);

  import gam_pkg::*;

  gam_state_t  state;
  gam_state_t  state_next;
  logic [31:0] n_q;
  logic        accept;
  logic        last_word;
  logic        start_ok;
  logic        bad_count;

  assign accept    = s_valid && s_ready;
  assign bad_count = (n_q == 32'd0) || (n_q > 32'(MAX_SUBSETS));
  // A start is honoured only when no load is in flight.
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_next = ST_CHECK;
      ST_CHECK: state_next = bad_count ? ST_ERROR : ST_WRITE;
      ST_WRITE: if (accept && last_word) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_CHECK: busy = 1'b1;
      ST_WRITE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_FLUSH: busy = 1'b1;
      default: ;
    endcase
  end

  gam_param_addr_gen #(
    .ADDR_W           (ADDR_W),
    .WORDS_PER_SUBSET (WORDS_PER_SUBSET)
  ) u_addr_gen (
    .clock       (clock),
    .reset       (reset),
    .init        (state == ST_CHECK),
    .num_subsets (n_q),
    .advance     (accept),
    .last        (last_word),
    .addr        (param_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      n_q             <= '0;
      param_ea        <= 1'b0;
      param_wea       <= 4'h0;
      param_din       <= '0;
      parameters_done <= 1'b0;
      load_error      <= 1'b0;
      words_written   <= '0;
    end else begin
      param_ea  <= accept;
      param_wea <= accept ? 4'hF : 4'h0;
      if (accept) begin
        param_din     <= s_data;
        words_written <= words_written + 32'd1;
      end
      if (start_ok) begin
        n_q             <= num_of_subsets;
        parameters_done <= 1'b0;
        load_error      <= 1'b0;
        words_written   <= '0;
      end
      if (state == ST_CHECK && bad_count) load_error <= 1'b1;
      // Done follows the flush cycle so memory is complete before it is seen.
      if (state == ST_FLUSH) parameters_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gam_param_writer.sv
// tb/tb_gam_param_writer.sv - randomized scoreboard bench for gam_param_writer
module tb_gam_param_writer;

  import gam_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_of_subsets;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        param_ea;
  logic [3:0]  param_wea;
  logic [31:0] param_addr;
  logic [31:0] param_din;
  logic        parameters_done;
  logic        busy;
  logic        load_error;
  logic [31:0] words_written;

  gam_param_writer dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .num_of_subsets  (num_of_subsets),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .param_ea        (param_ea),
    .param_wea       (param_wea),
    .param_addr      (param_addr),
    .param_din       (param_din),
    .parameters_done (parameters_done),
    .busy            (busy),
    .load_error      (load_error),
    .words_written   (words_written)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ww;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          ea_cycles = 0;
  int          last_acc_cyc = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] mem [0:127];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Word i of a load: header words first, then subset records of five fields each.
  function automatic logic [31:0] ref_addr(input int i);
    int s;
    int k;
    if (i < 5) return 32'(i * 4);
    s = (i - 5) / 5;
    k = (i - 5) % 5;
    return 32'(((s + 1) * 5 + k) * 4);
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (param_ea === 1'b1) begin
      ea_cycles++;
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(param_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", param_addr, e.addr);
        check("wr_data", param_din, e.data);
        check("wr_count", words_written, e.ww);
        check("wr_wea", 32'(param_wea), 32'hF);
      end
      mem[param_addr[8:2]] = param_din;
      last_addr = param_addr;
    end else if (param_wea !== 4'h0) begin
      check("idle_wea", 32'(param_wea), 32'h0);
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clock); #1;
    start = 1'b1;
    num_of_subsets = 32'(n);
    @(posedge clock); #1;
    start = 1'b0;
    num_of_subsets = $urandom;
  endtask

  task automatic check_reset_values();
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_ea", 32'(param_ea), 0);
    check("rst_wea", 32'(param_wea), 0);
    check("rst_addr", param_addr, 0);
    check("rst_din", param_din, 0);
    check("rst_done", 32'(parameters_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(load_error), 0);
    check("rst_ww", words_written, 0);
  endtask

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
  task automatic run_load(input int n, input int mode, input int restart_at,
                          input int reset_after, input logic [31:0] base);
    int total;
    int got;
    int budget;
    int seen;
    bit restarted;
    exp_t e;
    total = (n + 1) * 5;
    got = 0;
    budget = 0;
    restarted = 0;
    pulse_start(n);
    @(negedge clock);
    check("start_done_clear", 32'(parameters_done), 0);
    check("start_busy", 32'(busy), 1);
    check("start_ww_clear", words_written, 0);
    while (got < total && budget < 2000) begin
      @(posedge clock); #1;
      case (mode)
        0: s_valid = 1'b1;
        1: s_valid = (budget % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = (base != 0) ? base + 32'(got) : $urandom;
      start = (got == restart_at) && !restarted;
      if (start) begin
        num_of_subsets = 32'd5;
        restarted = 1;
      end
      budget++;
      @(negedge clock);
      if (s_valid && s_ready) begin
        e.addr = ref_addr(got);
        e.data = s_data;
        e.ww = 32'(got + 1);
        sb.push_back(e);
        last_acc_cyc = cyc;
        got++;
        if (reset_after > 0 && got == reset_after) break;
      end
    end
    @(posedge clock); #1;
    s_valid = 1'b0;
    start = 1'b0;
    if (reset_after > 0) begin
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_reset_values();
      check("rst_sb_empty", 32'(sb.size()), 0);
      sb.delete();
      return;
    end
    check("word_budget", 32'(got), 32'(total));
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (parameters_done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(cyc - last_acc_cyc), 2);
    check("done_ww", words_written, 32'(total));
    check("done_ready", 32'(s_ready), 0);
    check("done_busy", 32'(busy), 0);
    check("done_err", 32'(load_error), 0);
    check("done_sb_empty", 32'(sb.size()), 0);
  endtask

  task automatic run_bad(input int n);
    int ea0;
    ea0 = ea_cycles;
    pulse_start(n);
    @(posedge clock); #1;
    @(negedge clock);
    check("bad_err", 32'(load_error), 1);
    check("bad_done", 32'(parameters_done), 0);
    check("bad_busy", 32'(busy), 0);
    s_valid = 1'b1;
    repeat (4) @(negedge clock);
    check("bad_ready", 32'(s_ready), 0);
    check("bad_no_writes", 32'(ea_cycles - ea0), 0);
    s_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_of_subsets = '0;
    s_valid = 1'b0;
    s_data = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values();
    #1 reset = 1'b0;

    run_load(1, 0, -1, 0, 32'hA0);
    check("cx_subset0", mem[param_byte_addr(0, CX_OFS) >> 2], 32'hA8);
    check("cy_subset0", mem[param_byte_addr(0, CY_OFS) >> 2], 32'hA9);

    run_load(14, 1, -1, 0, 0);
    check("last_addr_n14", last_addr, 32'd296);
    repeat (3) @(negedge clock);
    check("ready_after_done", 32'(s_ready), 0);

    run_bad(0);
    run_bad(MAX_SUBSETS + 1);

    run_load(3, 2, -1, 7, 0);
    run_load(2, 2, -1, 0, 0);
    run_load(2, 2, 6, 0, 0);
    run_load(1, 2, -1, 0, 0);

    for (int r = 0; r < 4; r++) run_load(int'($urandom_range(1, MAX_SUBSETS)), 2, -1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
